serial_adder_unit: RTL and testbench

//   Bit-serial WIDTH-bit adder with valid/ready handshakes on input and output.

---
 rtl/serial_adder_unit.sv | 112 +++++++++++
 tb/tb_serial_adder_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_unit.sv
// Bit-serial WIDTH-bit adder: latches an operand pair, resolves one sum bit per
// cycle LSB first, and holds {cout, sum} until the consumer takes it.
module serial_adder_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_sel;
  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_sum_bit;
  logic             w_carry_nxt;
  logic             w_last;

  function automatic logic f_sum_bit(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic f_majority(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  // One-hot select of the bit position being resolved this cycle
  assign w_sel       = WIDTH'(1) << r_cnt;
  assign w_a_bit     = |(r_a & w_sel);
  assign w_b_bit     = |(r_b & w_sel);
  assign w_sum_bit   = f_sum_bit(w_a_bit, w_b_bit, r_carry);
  assign w_carry_nxt = f_majority(w_a_bit, w_b_bit, r_carry);
  assign w_last      = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_sum   <= '0;
          end
        end
        S_RUN: begin
          r_sum   <= (r_sum & ~w_sel) | (w_sum_bit ? w_sel : '0);
          r_carry <= w_carry_nxt;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) r_cout <= w_carry_nxt;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Directed bench for serial_adder_unit: a WIDTH=4 instance and a WIDTH=1 instance.
module tb_serial_adder_unit;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid, out_ready, cin;
  logic [3:0] a, b;
  logic       in_ready, out_valid, cout, busy;
  logic [3:0] sum;

  logic       in_valid1, out_ready1, cin1;
  logic [0:0] a1, b1, sum1;
  logic       in_ready1, out_valid1, cout1, busy1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder_unit #(.WIDTH(4)) u4 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder_unit #(.WIDTH(1)) u1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the unit in IDLE; returns at the falling edge after the handshake.
  task automatic accept(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts falling edges until out_valid is seen, bounded.
  task automatic wait_out(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    int n;
    logic [4:0] exp5;
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {28'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst1_in_ready", {31'd0, in_ready1}, 32'd1);
    resetn = 1'b1;
    @(negedge clk);

    // T2: F + 1 + 0, latency of exactly 4 cycles
    accept(4'hF, 4'h1, 1'b0);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    chk("t2_in_ready_run", {31'd0, in_ready}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("t2_no_early_valid", {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
    chk("t2_valid_at_4", {31'd0, out_valid}, 32'd1);
    chk("t2_sum", {28'd0, sum}, 32'h0);
    chk("t2_cout", {31'd0, cout}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t2_back_idle", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;

    // T3: F + F + 1 under 5 cycles of backpressure
    accept(4'hF, 4'hF, 1'b1);
    wait_out("t3_timeout", n);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_hold_sum", {28'd0, sum}, 32'hF);
      chk("t3_hold_cout", {31'd0, cout}, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_drop", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // T5: 9 + 9, reset at RUN cycle 2
    accept(4'h9, 4'h9, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_sum", {28'd0, sum}, 32'd0);
    chk("t5_cout", {31'd0, cout}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);

    // Reset while DONE is backpressured
    accept(4'hF, 4'h1, 1'b0);
    wait_out("rstdone_timeout", n);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rstdone_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstdone_cout", {31'd0, cout}, 32'd0);
    chk("rstdone_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // T4: 3 + 5, inputs wiggle during RUN
    accept(4'h3, 4'h5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_in_ready_run", {31'd0, in_ready}, 32'd0);
      a = 4'(i * 5 + 2); b = 4'(i * 3 + 7); cin = 1'b1; in_valid = ~in_valid;
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_out("t4_timeout", n);
    chk("t4_sum", {28'd0, sum}, 32'h8);
    chk("t4_cout", {31'd0, cout}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);

    // in_valid held high, out_ready high before out_valid: one operand set per transaction
    a = 4'h1; b = 4'h2; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 4'h7; b = 4'h7;
    wait_out("hold_timeout1", n);
    chk("hold_sum1", {28'd0, sum}, 32'h3);
    chk("hold_cout1", {31'd0, cout}, 32'd0);
    @(negedge clk);
    chk("hold_idle_gap", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out("hold_timeout2", n);
    chk("hold_sum2", {28'd0, sum}, 32'hE);
    chk("hold_cout2", {31'd0, cout}, 32'd0);
    @(negedge clk);

    // T1: exhaustive {cin,b,a}
    for (int v = 0; v < 512; v++) begin
      accept(v[3:0], v[7:4], v[8]);
      wait_out("t1_timeout", n);
      exp5 = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
      chk("t1_result", {27'd0, cout, sum}, {27'd0, exp5});
      chk("t1_latency", 32'(n), 32'd4);
      @(negedge clk);
    end
    out_ready = 1'b0;

    // T6: WIDTH=1, 1 + 1 + 1
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("t6_run_no_valid", {31'd0, out_valid1}, 32'd0);
    chk("t6_busy", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    chk("t6_valid", {31'd0, out_valid1}, 32'd1);
    chk("t6_sum", {31'd0, sum1}, 32'd1);
    chk("t6_cout", {31'd0, cout1}, 32'd1);
    out_ready1 = 1'b1;
    @(negedge clk);
    chk("t6_valid_drop", {31'd0, out_valid1}, 32'd0);

    // WIDTH=1, 1 + 0 + 0
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("t6b_sum", {30'd0, cout1, sum1}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
